// File: rtl/norm2_pkg.sv
// Shared types and defaults for the norm2 run sequencer.
// Holds the sequencer state enum, array geometry defaults and run-status bundle.
package norm2_pkg;

   localparam int ADDR_W_D = 10;
   localparam int DATA_W_D = 27;
   localparam int RES_W_D  = 64;
   localparam int DEPTH_D  = 1000;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      KICK,
      RUN
   } state_t;

   typedef struct packed {
      logic done;
      logic timeout;
      logic err;
   } run_status_t;

endpackage

// File: rtl/norm2_run_timer.sv
// Kernel run cycle counter with clear, enable and terminal-count flag.
// Ports: clk, rst, clr, en in; cyc (count), tc (cyc == TIMEOUT-1) out.
module norm2_run_timer #(
   parameter int CYC_W   = 32,
   parameter int TIMEOUT = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CYC_W-1:0] cyc,
   output logic             tc
);

   localparam logic [CYC_W-1:0] TC_VAL = CYC_W'(TIMEOUT - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc <= '0;
      end else if (clr) begin
         cyc <= '0;
      end else if (en) begin
         cyc <= cyc + CYC_W'(1);
      end
   end

   // tc marks the last RUN cycle the kernel is allowed
   assign tc = (cyc == TC_VAL);

endmodule

// File: rtl/norm2_run_ctrl.sv
// Sequencer: streams words into the kernel array, kicks the kernel and
// collects its result. Ports: start/len/abort host control, in_* stream,
// controlArr* array port a, r_enable/w_enable/result kernel handshake,
// busy/done/timeout/err status, out_result/out_cycles latched results.
module norm2_run_ctrl
   import norm2_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_D,
   parameter int DATA_W  = DATA_W_D,
   parameter int RES_W   = RES_W_D,
   parameter int DEPTH   = DEPTH_D,
   parameter int TIMEOUT = 100000,
   parameter int CYC_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              controlArr,
   output logic              controlArrWEnable_a,
   output logic [ADDR_W-1:0] controlArrAddr_a,
   output logic [DATA_W-1:0] controlArrWData_a,
   output logic              r_enable,
   output logic [63:0]       init_i,
   output logic [63:0]       init_acc,
   input  logic              w_enable,
   input  logic [RES_W-1:0]  result,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              err,
   output logic [RES_W-1:0]  out_result,
   output logic [CYC_W-1:0]  out_cycles
);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W-1:0] cnt;
   logic              len_ok;
   logic              last;
   logic              accept;
   logic              load_len;
   logic              tmr_clr;
   logic              tmr_en;
   logic              res_ld;
   logic              tc;
   logic [CYC_W-1:0]  cyc;
   run_status_t       stat_d;
   run_status_t       stat_q;

   assign len_ok = (len != '0) &&
                   (len <= (ADDR_W+1)'(DEPTH));
   assign last   = ({1'b0, cnt} ==
                    len_q - (ADDR_W+1)'(1));

   norm2_run_timer #(
      .CYC_W   (CYC_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .en  (tmr_en),
      .cyc (cyc),
      .tc  (tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      stat_d   = '0;
      accept   = 1'b0;
      load_len = 1'b0;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;
      res_ld   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  load_len = 1'b1;
                  state_nx = LOAD;
               end else begin
                  stat_d.err = 1'b1;
               end
            end
         end
         LOAD: begin
            if (in_valid) begin
               accept = 1'b1;
               if (last) begin
                  state_nx = KICK;
               end
            end
         end
         KICK: begin
            tmr_clr  = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            tmr_en = 1'b1;
            // done beats timeout when both land together
            if (w_enable) begin
               res_ld      = 1'b1;
               stat_d.done = 1'b1;
               state_nx    = IDLE;
            end else if (tc) begin
               stat_d.timeout = 1'b1;
               state_nx       = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // abort silences pulses, writes and latches
      if (abort) begin
         state_nx = IDLE;
         stat_d   = '0;
         accept   = 1'b0;
         load_len = 1'b0;
         res_ld   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q      <= '0;
         cnt        <= '0;
         stat_q     <= '0;
         out_result <= '0;
         out_cycles <= '0;
      end else begin
         stat_q <= stat_d;
         if (load_len) begin
            len_q <= len;
            cnt   <= '0;
         end else if (accept) begin
            cnt <= cnt + ADDR_W'(1);
         end
         if (res_ld) begin
            out_result <= result;
            out_cycles <= cyc + CYC_W'(1);
         end
      end
   end

   assign in_ready   = (state == LOAD);
   assign controlArr = (state == IDLE) ||
                       (state == LOAD);
   assign r_enable   = (state == KICK);
   assign busy       = (state != IDLE);

   // write lands on the same edge that accepts the word
   assign controlArrWEnable_a = accept;
   assign controlArrAddr_a    =
      (state == LOAD) ? cnt : '0;
   assign controlArrWData_a   =
      (state == LOAD) ? in_data : '0;

   assign init_i   = 64'd0;
   assign init_acc = 64'd0;

   assign done    = stat_q.done;
   assign timeout = stat_q.timeout;
   assign err     = stat_q.err;

endmodule

// File: tb/tb_norm2_run_ctrl.sv
// Directed bench for norm2_run_ctrl with a behavioural kernel and array.
// Ports: none; drives the DUT and prints one summary line.
module tb_norm2_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] len = '0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [26:0] in_data = '0;
   logic        in_ready;
   logic        controlArr;
   logic        we;
   logic [9:0]  waddr;
   logic [26:0] wdata;
   logic        r_enable;
   logic [63:0] init_i;
   logic [63:0] init_acc;
   logic        w_enable = 1'b0;
   logic [63:0] result = '0;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        err;
   logic [63:0] out_result;
   logic [31:0] out_cycles;

   norm2_run_ctrl #(
      .ADDR_W(10), .DATA_W(27), .RES_W(64),
      .DEPTH(1000), .TIMEOUT(16), .CYC_W(32)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready),
      .controlArr(controlArr),
      .controlArrWEnable_a(we),
      .controlArrAddr_a(waddr),
      .controlArrWData_a(wdata),
      .r_enable(r_enable), .init_i(init_i),
      .init_acc(init_acc), .w_enable(w_enable),
      .result(result), .busy(busy), .done(done),
      .timeout(timeout), .err(err),
      .out_result(out_result),
      .out_cycles(out_cycles)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      else
         n_pass++;
   endtask

   // array model and monitors
   logic signed [26:0] mem [0:1023];
   logic [26:0] words [0:999];
   int wq[$];
   int tcyc = 0;
   int last_wr = 0;
   int ren_cnt = 0, ren_cyc = 0;
   int done_cnt = 0, done_cyc = 0;
   int to_cnt = 0, to_cyc = 0;
   int err_cnt = 0;
   int wen_cyc = 0;

   always @(posedge clk) begin
      if (we && controlArr) begin
         mem[waddr] = wdata;
         wq.push_back(int'(waddr));
         last_wr = tcyc;
      end
      tcyc++;
   end

   // kernel: sum of squares, w_enable kdelay cycles after r_enable
   bit kon = 1'b1;
   bit kforce = 1'b0;
   int kdelay = 3;
   int kcnt = 0;
   int klen = 0;

   always @(negedge clk) begin
      longint s;
      w_enable = kforce;
      if (kcnt > 0) begin
         kcnt--;
         if (kcnt == 0) begin
            s = 0;
            for (int j = 0; j < klen; j++)
               s += longint'(mem[j]) * longint'(mem[j]);
            result = s;
            w_enable = 1'b1;
            wen_cyc = tcyc;
         end
      end
      if (r_enable) begin
         ren_cnt++;
         ren_cyc = tcyc;
         if (kon) kcnt = kdelay;
      end
      if (done) begin done_cnt++; done_cyc = tcyc; end
      if (timeout) begin to_cnt++; to_cyc = tcyc; end
      if (err) err_cnt++;
   end

   task automatic run_load(input int L, input bit gaps);
      int i;
      bit ph;
      klen = L;
      @(negedge clk);
      start = 1'b1;
      len = 11'(L);
      @(negedge clk);
      start = 1'b0;
      i = 0;
      ph = 1'b0;
      while (i < L) begin
         if (gaps && ph) begin
            in_valid = 1'b0;
            in_data = 27'h555_5555;
         end else begin
            in_valid = 1'b1;
            in_data = words[i];
            i++;
         end
         ph = ~ph;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data = '0;
   endtask

   task automatic wait_idle(input string name,
                            input int maxc);
      for (int c = 0; c < maxc && busy; c++)
         @(negedge clk);
      chk(name, busy, 0);
   endtask

   typedef struct {
      logic [10:0] len;
      logic        err;
      logic        busy;
      logic        rdy;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int e0, r0, d0, t0, bad;
      longint sw;
      logic [63:0] last_res;

      tbl[0] = '{11'd0,    1'b1, 1'b0, 1'b0};
      tbl[1] = '{11'd1001, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{11'd2047, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{11'd1,    1'b0, 1'b1, 1'b1};
      tbl[4] = '{11'd1000, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{11'd7,    1'b0, 1'b1, 1'b1};

      #3;
      chk("rst_busy", busy, 0);
      chk("rst_ctrl", controlArr, 1);
      chk("rst_ready", in_ready, 0);
      chk("rst_ren", r_enable, 0);
      chk("rst_we", we, 0);
      chk("rst_res", out_result, 0);
      chk("rst_cyc", out_cycles, 0);
      @(negedge clk);
      rst = 1'b0;

      // len legality table
      e0 = err_cnt;
      r0 = ren_cnt;
      wq.delete();
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         start = 1'b1;
         len = tbl[v].len;
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("tbl%0d_err", v), err, tbl[v].err);
         chk($sformatf("tbl%0d_busy", v), busy, tbl[v].busy);
         chk($sformatf("tbl%0d_rdy", v), in_ready, tbl[v].rdy);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         chk($sformatf("tbl%0d_abort", v), busy, 0);
         chk($sformatf("tbl%0d_noerr", v), err, 0);
      end
      chk("tbl_errcnt", err_cnt - e0, 3);
      chk("tbl_nowrite", wq.size(), 0);
      chk("tbl_noren", ren_cnt - r0, 0);

      // len=4 with gaps, kernel answers 3 cycles after kick
      for (int i = 0; i < 4; i++) words[i] = 27'(i + 1);
      wq.delete();
      d0 = done_cnt;
      kon = 1'b1;
      kdelay = 3;
      run_load(4, 1'b1);
      wait_idle("g4_idle", 40);
      @(negedge clk);
      chk("g4_nwr", wq.size(), 4);
      bad = 0;
      for (int i = 0; i < wq.size(); i++)
         if (wq[i] != i || mem[i] != 27'(i + 1)) bad++;
      chk("g4_wr_seq", bad, 0);
      chk("g4_res", out_result, 30);
      chk("g4_cyc", out_cycles, 3);
      chk("g4_done", done_cnt - d0, 1);
      chk("g4_done_lat", done_cyc - wen_cyc, 1);

      // reset during LOAD after 5 accepts
      @(negedge clk);
      start = 1'b1;
      len = 11'd10;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = 27'(100 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_ctrl", controlArr, 1);
      chk("mrst_ready", in_ready, 0);
      chk("mrst_res", out_result, 0);
      @(negedge clk);
      rst = 1'b0;

      // full 1000-word run
      sw = 0;
      for (int i = 0; i < 1000; i++) begin
         words[i] = 27'($urandom_range(0, (1 << 26) - 1));
         sw += longint'(words[i]) * longint'(words[i]);
      end
      wq.delete();
      d0 = done_cnt;
      r0 = ren_cnt;
      run_load(1000, 1'b0);
      wait_idle("full_idle", 40);
      @(negedge clk);
      chk("full_nwr", wq.size(), 1000);
      bad = 0;
      for (int i = 0; i < wq.size(); i++)
         if (wq[i] != i) bad++;
      chk("full_addr", bad, 0);
      chk("full_ren1", ren_cnt - r0, 1);
      chk("full_ren_lat", ren_cyc - last_wr, 1);
      chk("full_done", done_cnt - d0, 1);
      chk("full_res", out_result, 64'(sw));
      chk("full_cyc", out_cycles, 3);
      last_res = 64'(sw);

      // timeout: RUN lasts TIMEOUT cycles, pulse follows
      kon = 1'b0;
      d0 = done_cnt;
      t0 = to_cnt;
      words[0] = 27'd9;
      words[1] = 27'd8;
      run_load(2, 1'b0);
      wait_idle("to_idle", 40);
      @(negedge clk);
      chk("to_pulse", to_cnt - t0, 1);
      chk("to_lat", to_cyc - ren_cyc, 17);
      chk("to_nodone", done_cnt - d0, 0);
      chk("to_res", out_result, last_res);

      // w_enable on the final allowed cycle: done wins
      kon = 1'b1;
      kdelay = 16;
      d0 = done_cnt;
      t0 = to_cnt;
      run_load(2, 1'b0);
      wait_idle("tie_idle", 40);
      @(negedge clk);
      chk("tie_done", done_cnt - d0, 1);
      chk("tie_noto", to_cnt - t0, 0);
      chk("tie_cyc", out_cycles, 16);
      chk("tie_res", out_result, 145);

      // abort in RUN
      kon = 1'b0;
      d0 = done_cnt;
      t0 = to_cnt;
      e0 = err_cnt;
      run_load(1, 1'b0);
      @(negedge clk);
      chk("ab_inrun", controlArr, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_idle", busy, 0);
      chk("ab_ctrl", controlArr, 1);
      repeat (20) @(negedge clk);
      chk("ab_pulses",
          (done_cnt - d0) + (to_cnt - t0) + (err_cnt - e0), 0);

      // w_enable while idle
      d0 = done_cnt;
      kforce = 1'b1;
      @(negedge clk);
      kforce = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wen_idle", done_cnt - d0, 0);
      chk("wen_idle_res", out_cycles, 16);

      // start during RUN is ignored
      kon = 1'b1;
      kdelay = 5;
      d0 = done_cnt;
      words[0] = 27'd2;
      words[1] = 27'd3;
      run_load(2, 1'b0);
      @(negedge clk);
      start = 1'b1;
      len = 11'd3;
      @(negedge clk);
      start = 1'b0;
      wait_idle("sr_idle", 40);
      repeat (3) @(negedge clk);
      chk("sr_stay", busy, 0);
      chk("sr_done", done_cnt - d0, 1);
      chk("sr_cyc", out_cycles, 5);
      chk("sr_res", out_result, 13);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
